seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeat_cnt times, with optional idle gaps.
// Optional trailing even-parity bit per frame when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx #(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1101,
    parameter int unsigned          GAP_LEN = 2,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
`ifdef SEQ_PATTERN_TX_PARITY_EN
        ,S_PAR = 2'd3
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [3:0]         gap_q, gap_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               frame_end_c;
    logic               next_frame_c;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bit_idx_q     <= '0;
            gap_q         <= '0;
            rem_q         <= '0;
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            gap_q         <= gap_d;
            rem_q         <= rem_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        gap_d         = gap_q;
        rem_d         = rem_q;
        out_d         = 1'b0;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        frame_end_c   = 1'b0;
        next_frame_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (repeat_cnt != '0) begin
                        rem_d        = repeat_cnt;
                        next_frame_c = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (bit_idx_q != '0) begin
                    bit_idx_d   = bit_idx_q - IDX_W'(1);
                    out_d       = PATTERN[bit_idx_d];
                    out_valid_d = 1'b1;
                end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d     = S_PAR;
                    out_d       = ^PATTERN;
                    out_valid_d = 1'b1;
`else
                    frame_end_c = 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    next_frame_c = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            S_PAR: begin
                frame_end_c = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // rem is always >= 1 while sending, so the decrement never wraps
        if (frame_end_c) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_d == '0) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (GAP_LEN != 0) begin
                state_d = S_GAP;
                gap_d   = '0;
            end else begin
                next_frame_c = 1'b1;
            end
        end

        if (next_frame_c) begin
            state_d       = S_SEND;
            bit_idx_d     = LAST_IDX;
            out_d         = PATTERN[PAT_LEN-1];
            out_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: instance A uses GAP_LEN=2, instance B uses GAP_LEN=0.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] rc_a = 8'd0, rc_b = 8'd0;
    logic       out_a, valid_a, fs_a, busy_a, done_a;
    logic       out_b, valid_b, fs_b, busy_b, done_b;

    logic [31:0] cap_out, cap_valid, cap_fs, cap_busy, cap_done;
    int n_vec = 0;
    int n_err = 0;
    int done_cnt;
    int valid_cnt;

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_LEN(4), .PATTERN(4'b1101), .GAP_LEN(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .repeat_cnt(rc_a),
        .out(out_a), .out_valid(valid_a), .frame_start(fs_a), .busy(busy_a), .done(done_a)
    );

    seq_pattern_tx #(.PAT_LEN(4), .PATTERN(4'b1101), .GAP_LEN(0), .CNT_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .repeat_cnt(rc_b),
        .out(out_b), .out_valid(valid_b), .frame_start(fs_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Called at a negedge: start with repeat count n, capture ncyc cycles after the sampling edge.
    // start is held for 'hold' cycles; 'poke' >= 0 pulses start (repeat 5) at that cycle index.
    task automatic run(input bit sel, input logic [7:0] n, input int ncyc, input int hold,
                       input int poke);
        cap_out = '0; cap_valid = '0; cap_fs = '0; cap_busy = '0; cap_done = '0;
        if (sel) begin start_b = 1'b1; rc_b = n; end
        else     begin start_a = 1'b1; rc_a = n; end
        @(posedge clk);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cap_out   = {cap_out[30:0],   sel ? out_b   : out_a};
            cap_valid = {cap_valid[30:0], sel ? valid_b : valid_a};
            cap_fs    = {cap_fs[30:0],    sel ? fs_b    : fs_a};
            cap_busy  = {cap_busy[30:0],  sel ? busy_b  : busy_a};
            cap_done  = {cap_done[30:0],  sel ? done_b  : done_a};
            if (i == hold - 1) begin
                if (sel) start_b = 1'b0; else start_a = 1'b0;
            end
            if (poke >= 0 && i == poke) begin
                if (sel) begin start_b = 1'b1; rc_b = 8'd5; end
                else     begin start_a = 1'b1; rc_a = 8'd5; end
            end
            if (poke >= 0 && i == poke + 1) begin
                if (sel) start_b = 1'b0; else start_a = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outs_a", {27'd0, out_a, valid_a, fs_a, busy_a, done_a}, 32'd0);
        chk("reset_outs_b", {27'd0, out_b, valid_b, fs_b, busy_b, done_b}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef SEQ_PATTERN_TX_PARITY_EN
        run(1'b0, 8'd1, 6, 1, -1);
        chk("par_out",   cap_out,   32'b110110);
        chk("par_valid", cap_valid, 32'b111110);
        chk("par_fs",    cap_fs,    32'b100000);
        chk("par_busy",  cap_busy,  32'b111110);
        chk("par_done",  cap_done,  32'b000001);
`else
        // single frame
        run(1'b0, 8'd1, 5, 1, -1);
        chk("single_out",   cap_out,   32'b11010);
        chk("single_valid", cap_valid, 32'b11110);
        chk("single_fs",    cap_fs,    32'b10000);
        chk("single_busy",  cap_busy,  32'b11110);
        chk("single_done",  cap_done,  32'b00001);

        // three frames separated by two-cycle gaps
        run(1'b0, 8'd3, 18, 1, -1);
        chk("gap_out",   cap_out,   32'b110100_110100_110100);
        chk("gap_valid", cap_valid, 32'b111100_111100_111100);
        chk("gap_fs",    cap_fs,    32'b100000_100000_100000);
        chk("gap_busy",  cap_busy,  32'b111111_111111_111100);
        chk("gap_done",  cap_done,  32'b000000_000000_000010);

        // zero repeat count
        run(1'b0, 8'd0, 3, 1, -1);
        chk("zero_done",  cap_done,  32'b100);
        chk("zero_busy",  cap_busy,  32'b000);
        chk("zero_valid", cap_valid, 32'b000);

        // back-to-back frames, start held across the done cycle
        run(1'b1, 8'd2, 18, 10, -1);
        chk("b2b_out",   cap_out,   32'b110111010_110111010);
        chk("b2b_valid", cap_valid, 32'b111111110_111111110);
        chk("b2b_fs",    cap_fs,    32'b100010000_100010000);
        chk("b2b_busy",  cap_busy,  32'b111111110_111111110);
        chk("b2b_done",  cap_done,  32'b000000001_000000001);

        // start while busy is ignored
        run(1'b0, 8'd1, 8, 1, 1);
        chk("ign_out",   cap_out,   32'b11010000);
        chk("ign_valid", cap_valid, 32'b11110000);
        chk("ign_done",  cap_done,  32'b00001000);

        // reset mid-frame
        start_a = 1'b1; rc_a = 8'd2;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        chk("rst_pre", {29'd0, out_a, valid_a, busy_a}, 32'b111);
        reset = 1'b1;
        #1;
        chk("rst_async", {28'd0, out_a, valid_a, fs_a, busy_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        valid_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a) done_cnt++;
            if (valid_a) valid_cnt++;
        end
        chk("rst_no_done",  32'(done_cnt),  32'd0);
        chk("rst_no_valid", 32'(valid_cnt), 32'd0);
        run(1'b0, 8'd1, 5, 1, -1);
        chk("rst_fresh_out",  cap_out,  32'b11010);
        chk("rst_fresh_done", cap_done, 32'b00001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
